keypad_scan_4x5: RTL and testbench
==================================

Name: keypad_scan_4x5

Overview:
Matrix-keypad scanner that produces key codes for the SEnter-style entry logic.
- Drives the 4x5 keypad rows and samples the columns.
- Debounces one key at a time and presents a 5-bit code with D_ready.
- Holds the code until the consumer acknowledges by pulling readn low.
- Sits between the board keypad pins and the 2x32-bit operand-entry block; it is the producer side of the D_ready/readn/Din handshake.

Parameters:
ROWS, 4, number of driven rows (ROWS*COLS <= 32)
COLS, 5, number of sensed columns
SCAN_DIV, 16, clock cycles each row is held low (dwell); must be >= 2
DEBOUNCE, 4, consecutive identical sweeps required to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
col_in  input  COLS  column sense lines, active-low (pulled up, low = contact on driven row)
row_out  output  ROWS  row drive, one-hot active-low
readn  input  1  consumer read strobe; 0 = code taken
D_ready  output  1  key code valid
Dout  output  5  key code = row*COLS + col

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- Reset values: row_out = all-ones except bit0 low (4'b1110 by default); D_ready = 0; Dout = 0; state = IDLE; dwell, row and debounce counters = 0; candidate = 0.
- rst asserted in any state, including REPORT, forces these values on the next edge. Any pending code is discarded.
- Row sweep:
  - The dwell counter counts 0..SCAN_DIV-1 while row r is driven low.
  - col_in is sampled only at dwell count SCAN_DIV-1 (settling time).
  - On that cycle the row index advances (ROWS-1 wraps to 0) and the dwell counter returns to 0.
  - One sweep = ROWS*SCAN_DIV cycles.
- Per-sweep result, evaluated on the sample cycle of the last row (ROWS-1):
  - NONE: no low column on any row.
  - SINGLE(code): exactly one low contact in the whole sweep. Code = row*COLS + index of the low column.
  - MULTI: two or more low contacts.
- The rest of the FSM advances only on sweep-end cycles. States:
  - IDLE: SINGLE(c) -> candidate = c, cnt = 1, go to DEBOUNCE (or directly to REPORT if DEBOUNCE = 1). NONE or MULTI -> stay.
  - DEBOUNCE:
    - SINGLE(candidate) -> cnt++; when cnt reaches DEBOUNCE, load Dout = candidate, set D_ready = 1, go to REPORT.
    - SINGLE(other) -> candidate = other, cnt = 1.
    - NONE or MULTI -> IDLE.
  - REPORT:
    - D_ready = 1 and Dout is held stable.
    - On any edge (not only sweep end) where readn == 0, D_ready = 0 on that edge's update, go to WAIT_RELEASE, cnt = 0.
    - Key release or a new key while in REPORT is ignored; the latched code survives.
  - WAIT_RELEASE: NONE -> cnt++; when cnt reaches DEBOUNCE, go to IDLE. SINGLE or MULTI -> cnt = 0.
- Row scanning runs continuously in every state.
- readn == 0 outside REPORT is ignored.
- Each physical press yields exactly one report; there is no auto-repeat.
- Dout keeps its last value after D_ready falls.
- Press-to-D_ready latency: D_ready rises on the sweep-end edge of the DEBOUNCE-th consecutive matching sweep.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum {IDLE, DEBOUNCE, REPORT, WAIT_RELEASE};
  - KEY_CODE_W = 5;
  - sweep-result enum {RES_NONE, RES_SINGLE, RES_MULTI}.
- One sub-module, keypad_row_sweep, holds the dwell counter, row drive, per-sweep contact accumulator and result/code.
  - Outputs a one-cycle sweep_done pulse together with result and code.
- The top level contains the FSM, debounce counter and handshake registers.

Test Plan:
All scenarios use SCAN_DIV = 4 and DEBOUNCE = 3, so one sweep = 16 cycles.
- Reset: rst = 1 for 2 cycles -> row_out = 4'b1110, D_ready = 0, Dout = 0. After release, row_out = 4'b1101 after 4 cycles and 4'b1110 again after 16 cycles.
- Clean press of row 2/col 3, held -> D_ready = 1 with Dout = 13 at the end of the 3rd sweep. Hold readn = 1 for 200 cycles -> D_ready and Dout stay stable. Pulse readn = 0 for 1 cycle -> D_ready = 0 on the next edge. Key still held -> no second report.
- Bounce: press row 0/col 1 for 1 sweep, open for 1 sweep, press for 2 sweeps, then hold -> no D_ready until 3 uninterrupted sweeps; then Dout = 1.
- Two keys, (0,0) and (1,4), held -> no report. Release (0,0) -> Dout = 9 reported after 3 sweeps.
- Release re-arm: after ack of code 7, release for 2 sweeps and re-press -> no report. Release for 3 full sweeps, then press -> second report with Dout = 7.
- rst asserted mid-REPORT (D_ready = 1, Dout = 18) -> next edge D_ready = 0, Dout = 0, row_out = 4'b1110. Key still held -> fresh report after 3 sweeps.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the 4x5 keypad scanner: FSM states, sweep results and key-code width.
package keypad_pkg;

  localparam int KEY_CODE_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_REPORT,
    S_WAIT_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } result_e;

endpackage

// File: rtl/keypad_row_sweep.sv
// Drives one row low at a time, samples the columns at the end of each dwell and
// classifies every full sweep as no contact, a single contact (with its code) or several.
module keypad_row_sweep
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 5,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLS-1:0]       col_i,
  output logic [ROWS-1:0]       row_o,
  output logic                  sweep_done_o,
  output result_e               result_o,
  output logic [KEY_CODE_W-1:0] code_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  logic [DW-1:0]         dwell_q, dwell_d;
  logic [RW-1:0]         row_q, row_d;
  logic [1:0]            hits_q, hits_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;

  logic                  sample;
  logic                  lastRow;
  logic [1:0]            rowHits;
  logic [1:0]            sweepHits;
  logic [2:0]            hitSum;
  logic [KEY_CODE_W-1:0] rowCode;
  logic [KEY_CODE_W-1:0] sweepCode;

  // Contact count saturates at 2: beyond that only "several" matters.
  always_comb begin
    sample  = (dwell_q == DWELL_LAST);
    lastRow = (row_q == ROW_LAST);
    rowHits = '0;
    rowCode = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_i[c]) begin
        if (rowHits != 2'd2) rowHits = rowHits + 2'd1;
        rowCode = KEY_CODE_W'(int'(row_q) * COLS + c);
      end
    end
    hitSum    = {1'b0, hits_q} + {1'b0, rowHits};
    sweepHits = (hitSum > 3'd1) ? 2'd2 : hitSum[1:0];
    sweepCode = (hits_q == 2'd0) ? rowCode : code_q;

    dwell_d = dwell_q + DW'(1);
    row_d   = row_q;
    hits_d  = hits_q;
    code_d  = code_q;
    if (sample) begin
      dwell_d = '0;
      if (lastRow) begin
        row_d  = '0;
        hits_d = '0;
        code_d = '0;
      end else begin
        row_d  = row_q + RW'(1);
        hits_d = sweepHits;
        code_d = sweepCode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      row_q   <= '0;
      hits_q  <= '0;
      code_q  <= '0;
    end else begin
      dwell_q <= dwell_d;
      row_q   <= row_d;
      hits_q  <= hits_d;
      code_q  <= code_d;
    end
  end

  assign row_o        = ~(ROWS'(1) << row_q);
  assign sweep_done_o = sample && lastRow;
  assign code_o       = sweepCode;

  always_comb begin
    result_o = RES_MULTI;
    if (sweepHits == 2'd0)      result_o = RES_NONE;
    else if (sweepHits == 2'd1) result_o = RES_SINGLE;
  end

endmodule

// File: rtl/keypad_scan_4x5.sv
// Keypad scanner top: debounces one key per press and offers its code on the
// D_ready/readn/Dout handshake until the consumer takes it.
module keypad_scan_4x5
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 5,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLS-1:0]       col_in,
  output logic [ROWS-1:0]       row_out,
  input  logic                  readn,
  output logic                  D_ready,
  output logic [KEY_CODE_W-1:0] Dout
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE);

  logic                  sweepDone;
  result_e               sweepResult;
  logic [KEY_CODE_W-1:0] sweepCode;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cntInc;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [KEY_CODE_W-1:0] dout_q, dout_d;
  logic                  dready_q, dready_d;

  keypad_row_sweep #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_sweep (
    .clk          (clk),
    .rst          (rst),
    .col_i        (col_in),
    .row_o        (row_out),
    .sweep_done_o (sweepDone),
    .result_o     (sweepResult),
    .code_o       (sweepCode)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    dout_d   = dout_q;
    dready_d = dready_q;
    cntInc   = cnt_q + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (sweepDone && sweepResult == RES_SINGLE) begin
          cand_d = sweepCode;
          cnt_d  = CW'(1);
          if (DEBOUNCE == 1) begin
            dout_d   = sweepCode;
            dready_d = 1'b1;
            state_d  = S_REPORT;
          end else begin
            state_d = S_DEBOUNCE;
          end
        end
      end

      S_DEBOUNCE: begin
        if (sweepDone) begin
          if (sweepResult == RES_SINGLE && sweepCode == cand_q) begin
            cnt_d = cntInc;
            if (cntInc == CNT_TARGET) begin
              dout_d   = cand_q;
              dready_d = 1'b1;
              state_d  = S_REPORT;
            end
          end else if (sweepResult == RES_SINGLE) begin
            cand_d = sweepCode;
            cnt_d  = CW'(1);
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      // The acknowledge is honoured on any edge, not just at sweep end.
      S_REPORT: begin
        if (!readn) begin
          dready_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_WAIT_RELEASE;
        end
      end

      S_WAIT_RELEASE: begin
        if (sweepDone) begin
          if (sweepResult == RES_NONE) begin
            cnt_d = cntInc;
            if (cntInc == CNT_TARGET) begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      dout_q   <= '0;
      dready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      dout_q   <= dout_d;
      dready_q <= dready_d;
    end
  end

  assign D_ready = dready_q;
  assign Dout    = dout_q;

endmodule

// File: tb/tb_keypad_scan_4x5.sv
// Bench for keypad_scan_4x5: a keypad model drives the columns, and a sweep-level
// reference model predicts row drive, D_ready and Dout on every clock.
module tb_keypad_scan_4x5;

  localparam int ROWS     = 4;
  localparam int COLS     = 5;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SWEEP    = ROWS * SCAN_DIV;
  localparam int NKEYS    = ROWS * COLS;

  localparam int LOOKING = 0;
  localparam int HOLDING = 1;
  localparam int QUIET   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            readn;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic            D_ready;
  logic [4:0]      Dout;

  logic [NKEYS-1:0] keys;

  int nCompared   = 0;
  int nMismatched = 0;

  int         mT;
  int         mPhase;
  int         mStreak;
  int         mCand;
  int         mQuiet;
  logic       mDready;
  logic [4:0] mDout;
  int         hits[$];

  keypad_scan_4x5 #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .col_in  (col_in),
    .row_out (row_out),
    .readn   (readn),
    .D_ready (D_ready),
    .Dout    (Dout)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row whenever that row is driven low.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-sweep list of contacts seen at each row's sample instant,
  // then press/hold/release rules applied once per sweep.
  task modelEdge();
    int  dwell;
    int  row;
    bit  sweepEnd;
    if (rst) begin
      mT = 0; mPhase = LOOKING; mStreak = 0; mCand = 0; mQuiet = 0;
      mDready = 1'b0; mDout = '0;
      hits.delete();
    end else begin
      dwell    = mT % SCAN_DIV;
      row      = (mT / SCAN_DIV) % ROWS;
      sweepEnd = 1'b0;
      if (dwell == SCAN_DIV - 1) begin
        for (int c = 0; c < COLS; c++)
          if (keys[row*COLS+c]) hits.push_back(row*COLS + c);
        if (row == ROWS - 1) sweepEnd = 1'b1;
      end
      if (mPhase == HOLDING) begin
        if (!readn) begin
          mDready = 1'b0;
          mPhase  = QUIET;
          mQuiet  = 0;
        end
      end else if (mPhase == LOOKING && sweepEnd) begin
        if (hits.size() == 1) begin
          if (mStreak > 0 && hits[0] == mCand) mStreak++;
          else begin
            mCand   = hits[0];
            mStreak = 1;
          end
          if (mStreak == DEB) begin
            mDout   = 5'(mCand);
            mDready = 1'b1;
            mPhase  = HOLDING;
          end
        end else begin
          mStreak = 0;
        end
      end else if (mPhase == QUIET && sweepEnd) begin
        if (hits.size() == 0) begin
          mQuiet++;
          if (mQuiet == DEB) begin
            mPhase  = LOOKING;
            mStreak = 0;
          end
        end else begin
          mQuiet = 0;
        end
      end
      if (sweepEnd) hits.delete();
      mT++;
    end
  endtask

  task checkOutput();
    logic [ROWS-1:0] expRow;
    expRow = ~(ROWS'(1) << ((mT / SCAN_DIV) % ROWS));
    checkValue("row_out", 32'(row_out), 32'(expRow));
    checkValue("D_ready", 32'(D_ready), 32'(mDready));
    checkValue("Dout", 32'(Dout), 32'(mDout));
  endtask

  task tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task alignSweep();
    for (int i = 0; i < SWEEP && (mT % SWEEP) != 0; i++) tick();
  endtask

  task ackPulse();
    readn = 1'b0;
    tick();
    readn = 1'b1;
  endtask

  task rearm();
    keys = '0;
    ticks(4 * SWEEP);
    alignSweep();
  endtask

  initial begin
    int r;
    rst   = 1'b1;
    readn = 1'b1;
    keys  = '0;

    ticks(2);
    checkValue("reset_row", 32'(row_out), 32'h0000000e);
    checkValue("reset_ready", 32'(D_ready), 32'd0);
    checkValue("reset_dout", 32'(Dout), 32'd0);
    rst = 1'b0;
    ticks(4);
    checkValue("row1_after_4", 32'(row_out), 32'h0000000d);
    ticks(12);
    checkValue("row0_after_16", 32'(row_out), 32'h0000000e);

    $display("[TB] clean press of key 13");
    keys[13] = 1'b1;
    ticks(3 * SWEEP - 1);
    checkValue("press13_early", 32'(D_ready), 32'd0);
    tick();
    checkValue("press13_ready", 32'(D_ready), 32'd1);
    checkValue("press13_code", 32'(Dout), 32'd13);
    ticks(200);
    checkValue("press13_hold_ready", 32'(D_ready), 32'd1);
    checkValue("press13_hold_code", 32'(Dout), 32'd13);
    ackPulse();
    checkValue("press13_ack", 32'(D_ready), 32'd0);
    ticks(6 * SWEEP);
    checkValue("press13_no_repeat", 32'(D_ready), 32'd0);
    checkValue("press13_dout_kept", 32'(Dout), 32'd13);

    $display("[TB] bouncing key 1");
    rearm();
    keys[1] = 1'b1;
    ticks(SWEEP);
    keys[1] = 1'b0;
    ticks(SWEEP);
    keys[1] = 1'b1;
    ticks(2 * SWEEP);
    checkValue("bounce_not_yet", 32'(D_ready), 32'd0);
    ticks(SWEEP);
    checkValue("bounce_ready", 32'(D_ready), 32'd1);
    checkValue("bounce_code", 32'(Dout), 32'd1);
    ackPulse();

    $display("[TB] two keys then release one");
    rearm();
    keys[0] = 1'b1;
    keys[9] = 1'b1;
    ticks(5 * SWEEP);
    checkValue("multi_no_report", 32'(D_ready), 32'd0);
    keys[0] = 1'b0;
    ticks(3 * SWEEP - 1);
    checkValue("multi_release_early", 32'(D_ready), 32'd0);
    tick();
    checkValue("multi_release_ready", 32'(D_ready), 32'd1);
    checkValue("multi_release_code", 32'(Dout), 32'd9);
    ackPulse();

    $display("[TB] release re-arm with key 7");
    rearm();
    keys[7] = 1'b1;
    ticks(3 * SWEEP);
    checkValue("rearm_first_ready", 32'(D_ready), 32'd1);
    checkValue("rearm_first_code", 32'(Dout), 32'd7);
    ackPulse();
    alignSweep();
    keys[7] = 1'b0;
    ticks(2 * SWEEP);
    keys[7] = 1'b1;
    ticks(4 * SWEEP);
    checkValue("rearm_short_release", 32'(D_ready), 32'd0);
    keys[7] = 1'b0;
    ticks(3 * SWEEP);
    keys[7] = 1'b1;
    ticks(3 * SWEEP - 1);
    checkValue("rearm_second_early", 32'(D_ready), 32'd0);
    tick();
    checkValue("rearm_second_ready", 32'(D_ready), 32'd1);
    checkValue("rearm_second_code", 32'(Dout), 32'd7);
    ackPulse();

    $display("[TB] reset during report");
    rearm();
    keys[18] = 1'b1;
    ticks(3 * SWEEP);
    checkValue("rst_mid_ready_before", 32'(D_ready), 32'd1);
    checkValue("rst_mid_code_before", 32'(Dout), 32'd18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkValue("rst_mid_ready", 32'(D_ready), 32'd0);
    checkValue("rst_mid_dout", 32'(Dout), 32'd0);
    checkValue("rst_mid_row", 32'(row_out), 32'h0000000e);
    ticks(3 * SWEEP);
    checkValue("rst_mid_fresh_ready", 32'(D_ready), 32'd1);
    checkValue("rst_mid_fresh_code", 32'(Dout), 32'd18);
    ackPulse();

    $display("[TB] randomized key activity");
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 5) keys = '0;
      else if (r < 12) begin
        keys = '0;
        keys[$urandom_range(0, NKEYS - 1)] = 1'b1;
      end else if (r == 12) begin
        keys[$urandom_range(0, NKEYS - 1)] = 1'b1;
      end
      readn = ($urandom_range(0, 15) != 0);
      rst   = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst   = 1'b0;
    readn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
